mem_arbiter: RTL

- Sole owner of the byte-wide unified RAM port.
- Shares the port between the instruction fetcher (word reads only) and the load/store buffer (1/2/4-byte loads and stores).
- Serialises every request into byte accesses and reassembles little-endian read words.
- Arbitrates between the two requesters and honours pipeline flush (clear).

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial RAM port shared by the fetcher and the load/store buffer.
// Define MEM_ARB_IO_STALL_EN to hold back I/O stores while the UART buffer is full.
module mem_arbiter #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 32'h30000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  clear_flag_in,
    input  logic                  if_fetch_enable_in,
    input  logic [ADDR_WIDTH-1:0] if_addr_in,
    output logic                  if_result_enable_out,
    output logic [31:0]           if_data_out,
    input  logic                  lsb_enable_in,
    input  logic                  lsb_wr_in,
    input  logic [1:0]            lsb_size_in,
    input  logic [ADDR_WIDTH-1:0] lsb_addr_in,
    input  logic [31:0]           lsb_data_in,
    output logic                  lsb_result_enable_out,
    output logic [31:0]           lsb_data_out,
    input  logic [7:0]            ram_din,
    output logic [7:0]            ram_dout,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_wr,
    input  logic                  io_buffer_full
);
    typedef enum logic [1:0] {IDLE, IF_RD, LSB_RD, LSB_WR} state_e;
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
    logic [31:0]           wdata_q, wdata_d, buf_q, buf_d, if_data_q, if_data_d, lsb_data_q, lsb_data_d;
    logic [31:0]           rd_word;
    logic [7:0]            dout_q, dout_d;
    logic [2:0]            cnt_q, cnt_d, n_q, n_d, lsb_n;
    logic [1:0]            lane;
    logic                  ram_wr_q, ram_wr_d, last_lsb_q, last_lsb_d;
    logic                  if_res_q, if_res_d, lsb_res_q, lsb_res_d;
    logic                  lsb_req, grant_lsb, grant_if;
`ifdef MEM_ARB_IO_STALL_EN
    assign lsb_req = lsb_enable_in && !(lsb_wr_in && lsb_addr_in >= IO_BASE && io_buffer_full);
`else
    logic unused_io;
    assign unused_io = ^{io_buffer_full, IO_BASE};
    assign lsb_req   = lsb_enable_in;
`endif
    assign grant_lsb = lsb_req && (!if_fetch_enable_in || !last_lsb_q);
    assign grant_if  = if_fetch_enable_in && !grant_lsb;
    assign lsb_n     = lsb_size_in == 2'd0 ? 3'd1 : lsb_size_in == 2'd1 ? 3'd2 : 3'd4;
    // RAM returns the byte one cycle late, so cycle k delivers lane k-1
    assign lane      = 2'(cnt_q - 3'd1);
    always_comb begin
        rd_word                       = buf_q;
        rd_word[{lane, 3'b000} +: 8]  = ram_din;
    end
    always_comb begin
        state_d    = state_q;
        ram_a_d    = ram_a_q;
        ram_wr_d   = ram_wr_q;
        dout_d     = dout_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        last_lsb_d = last_lsb_q;
        if_res_d   = 1'b0;
        lsb_res_d  = 1'b0;
        if_data_d  = if_data_q;
        lsb_data_d = lsb_data_q;
        case (state_q)
            IDLE: if (!clear_flag_in && (grant_if || grant_lsb)) begin
                state_d    = grant_if ? IF_RD : lsb_wr_in ? LSB_WR : LSB_RD;
                ram_a_d    = grant_if ? if_addr_in : lsb_addr_in;
                ram_wr_d   = grant_lsb && lsb_wr_in;
                dout_d     = lsb_data_in[7:0];
                wdata_d    = lsb_data_in;
                n_d        = grant_if ? 3'd4 : lsb_n;
                buf_d      = '0;
                cnt_d      = '0;
                last_lsb_d = grant_lsb;
            end
            IF_RD, LSB_RD: if (clear_flag_in) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + 3'd1;
                buf_d = cnt_q == 3'd0 ? buf_q : rd_word;
                if (cnt_q + 3'd1 < n_q)
                    ram_a_d = ram_a_q + ADDR_WIDTH'(1);
                if (cnt_q == n_q) begin
                    state_d    = IDLE;
                    if_res_d   = state_q == IF_RD;
                    lsb_res_d  = state_q == LSB_RD;
                    if_data_d  = state_q == IF_RD ? rd_word : if_data_q;
                    lsb_data_d = state_q == LSB_RD ? rd_word : lsb_data_q;
                end
            end
            LSB_WR: if (cnt_q + 3'd1 == n_q) begin
                state_d   = IDLE;
                ram_wr_d  = 1'b0;
                lsb_res_d = 1'b1;
            end else begin
                cnt_d   = cnt_q + 3'd1;
                ram_a_d = ram_a_q + ADDR_WIDTH'(1);
                dout_d  = 8'(wdata_q >> {cnt_q[1:0] + 2'd1, 3'b000});
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ram_a_q    <= '0;
            ram_wr_q   <= 1'b0;
            dout_q     <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
            cnt_q      <= '0;
            n_q        <= '0;
            last_lsb_q <= 1'b0;
            if_res_q   <= 1'b0;
            lsb_res_q  <= 1'b0;
            if_data_q  <= '0;
            lsb_data_q <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            ram_a_q    <= ram_a_d;
            ram_wr_q   <= ram_wr_d;
            dout_q     <= dout_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            last_lsb_q <= last_lsb_d;
            if_res_q   <= if_res_d;
            lsb_res_q  <= lsb_res_d;
            if_data_q  <= if_data_d;
            lsb_data_q <= lsb_data_d;
        end
    end
    assign ram_a                 = ram_a_q;
    assign ram_wr                = ram_wr_q && rdy;
    assign ram_dout              = dout_q;
    assign if_result_enable_out  = if_res_q;
    assign if_data_out           = if_data_q;
    assign lsb_result_enable_out = lsb_res_q;
    assign lsb_data_out          = lsb_data_q;
endmodule
